if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: res_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have: imem_req  output  1  fetch request to instruction memory.
REQ-004 SHALL have: imem_addr  output  32  fetch byte address, word-aligned.
REQ-005 SHALL have: imem_gnt  input  1  request accepted in the same cycle.
REQ-006 SHALL have: imem_rvalid  input  1  read data valid, one or more cycles after the grant.
REQ-007 SHALL have: imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have: id_stall  input  1  ID cannot accept a new instruction; hold IF/ID.
REQ-009 SHALL have: ex_redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have: ex_redirect_pc  input  32  redirect target.
REQ-011 SHALL have: instruction  output  32  IF/ID instruction register.
REQ-012 SHALL have: if_id_pc  output  32  IF/ID PC of that instruction.
REQ-013 SHALL have: if_id_valid  output  1  IF/ID holds a real instruction.

Function
REQ-014 SHALL use FSM states FETCH, WAIT, HOLD and KILL, with one outstanding imem request at most.
REQ-015 FETCH: imem_req = !ex_redirect and imem_addr = pc; on imem_req && imem_gnt, req_pc<=pc, pc<=pc+4 (mod 2^32, FFFF_FFFC wraps to 0), go to WAIT.
REQ-016 WAIT: imem_req=0; on imem_rvalid, if IF/ID can accept (!if_id_valid || !id_stall), load instruction<=imem_rdata, if_id_pc<=req_pc, if_id_valid<=1, go to FETCH; otherwise capture rdata/req_pc in the hold buffer and go to HOLD.
REQ-017 HOLD: imem_req=0; when IF/ID can accept, load from the hold buffer, set valid, go to FETCH.
REQ-018 KILL: imem_req=0; discard the next imem_rvalid data and go to FETCH.
REQ-019 When id_stall=1 and valid=1, instruction, if_id_pc and if_id_valid SHALL hold.
REQ-020 When IF/ID can accept but nothing is loaded, the block SHALL set if_id_valid<=0 and instruction<=32'h0000_0013 (NOP).
REQ-021 ex_redirect SHALL have priority over every other event, including id_stall.
REQ-022 On ex_redirect, the block SHALL set pc<=ex_redirect_pc with bits [1:0] cleared, if_id_valid<=0 and instruction<=NOP.
REQ-023 Redirect state transitions: FETCH->FETCH with no request that cycle; HOLD->FETCH with the buffer dropped; WAIT with same-cycle rvalid->FETCH with data dropped; WAIT without rvalid->KILL; KILL->KILL.
REQ-024 Fetch-to-IF/ID latency SHALL be one cycle after the rvalid cycle; back-to-back fetch SHALL re-request in the cycle after the load.

Reset
REQ-025 While res_n=0 at a clk edge: pc=0, state=FETCH, if_id_valid=0, instruction=32'h0000_0013, if_id_pc=0, hold buffer cleared; imem_req=0 during reset.
REQ-026 Reset asserted mid-transaction SHALL abandon it; a late imem_rvalid arriving in FETCH after reset SHALL be ignored.

Configuration
REQ-027 Macro IF_MISALIGN_TRAP_EN defined: the block SHALL add output if_misalign (1 bit, reset 0), which pulses high for exactly one cycle after an ex_redirect whose ex_redirect_pc[1:0]!=0; pc is still loaded with [1:0] cleared.
REQ-028 Macro IF_MISALIGN_TRAP_EN undefined: if_misalign SHALL be absent and target bits [1:0] silently cleared.

Verification
REQ-029 Reset, then gnt always 1, rvalid one cycle after the grant -> imem_addr 0,4,8; IF/ID gets PCs 0,4,8 with valid=1.
REQ-030 id_stall=1 for 3 cycles while rvalid returns word 0x00500093 -> FSM enters HOLD and IF/ID is unchanged; after the stall drops, instruction=0x00500093 next cycle.
REQ-031 Redirect to 0x100 while in WAIT, then rvalid with 0xDEADBEEF -> KILL, data dropped, next imem_addr=0x100, IF/ID never shows 0xDEADBEEF.
REQ-032 ex_redirect and id_stall together with valid=1 -> if_id_valid=0 and instruction=0x00000013 next cycle.
REQ-033 pc=0xFFFF_FFFC is granted -> next imem_addr=0x0000_0000.
REQ-034 With IF_MISALIGN_TRAP_EN, redirect to 0x102 -> if_misalign=1 for one cycle and next imem_addr=0x100.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with a single outstanding imem request.
// Four-state fetch FSM (FETCH, WAIT, HOLD, KILL).
// A hold buffer parks returned data while ID is stalled.
// A taken branch/jump from EX flushes the IF/ID register and restarts
// fetching at the redirect target.
// Optional feature macro: IF_MISALIGN_TRAP_EN adds the if_misalign output.
// That output flags redirects to non-word-aligned targets.
module if_stage (
  input  logic        clk,
  input  logic        res_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        if_misalign
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] req_pc_r, req_pc_nxt_s;
  logic [31:0] hold_instr_r, hold_instr_nxt_s;
  logic [31:0] hold_pc_r, hold_pc_nxt_s;
  logic        accept_s;
  logic        load_s;
  logic [31:0] load_instr_s;
  logic [31:0] load_pc_s;
  logic [31:0] target_s;

  // IF/ID is free when it is empty or ID is consuming its current content.
  assign accept_s  = !if_id_valid || !id_stall;
  // Redirect target is forced onto a word boundary.
  assign target_s  = ex_redirect_pc & 32'hFFFF_FFFC;
  assign imem_addr = pc_r;

  // Next-state, PC, hold-buffer and IF/ID load selection; redirect wins over everything.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    req_pc_nxt_s     = req_pc_r;
    hold_instr_nxt_s = hold_instr_r;
    hold_pc_nxt_s    = hold_pc_r;
    load_s           = 1'b0;
    load_instr_s     = NOP;
    load_pc_s        = if_id_pc;
    imem_req         = 1'b0;
    case (state_r)
      FETCH: begin
        imem_req = res_n && !ex_redirect;
        if (ex_redirect) begin
          pc_nxt_s = target_s;
        end else if (imem_gnt) begin
          req_pc_nxt_s = pc_r;
          pc_nxt_s     = pc_r + 32'd4;
          state_nxt_s  = WAIT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      WAIT: begin
        if (ex_redirect) begin
          pc_nxt_s    = target_s;
          state_nxt_s = imem_rvalid ? FETCH : KILL;
        end else if (imem_rvalid) begin
          if (accept_s) begin
            load_s       = 1'b1;
            load_instr_s = imem_rdata;
            load_pc_s    = req_pc_r;
            state_nxt_s  = FETCH;
          end else begin
            hold_instr_nxt_s = imem_rdata;
            hold_pc_nxt_s    = req_pc_r;
            state_nxt_s      = HOLD;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD: begin
        if (ex_redirect) begin
          pc_nxt_s    = target_s;
          state_nxt_s = FETCH;
        end else if (accept_s) begin
          load_s       = 1'b1;
          load_instr_s = hold_instr_r;
          load_pc_s    = hold_pc_r;
          state_nxt_s  = FETCH;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      KILL: begin
        if (ex_redirect) begin
          pc_nxt_s    = target_s;
          state_nxt_s = KILL;
        end else if (imem_rvalid) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = KILL;
        end
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // FSM state, PC and hold-buffer registers.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_r      <= FETCH;
      pc_r         <= 32'h0000_0000;
      req_pc_r     <= 32'h0000_0000;
      hold_instr_r <= 32'h0000_0000;
      hold_pc_r    <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      req_pc_r     <= req_pc_nxt_s;
      hold_instr_r <= hold_instr_nxt_s;
      hold_pc_r    <= hold_pc_nxt_s;
    end
  end

  // IF/ID register: flush on redirect, load on delivery, bubble when free, else hold.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      instruction <= NOP;
      if_id_pc    <= 32'h0000_0000;
      if_id_valid <= 1'b0;
    end else if (ex_redirect) begin
      instruction <= NOP;
      if_id_valid <= 1'b0;
    end else if (load_s) begin
      instruction <= load_instr_s;
      if_id_pc    <= load_pc_s;
      if_id_valid <= 1'b1;
    end else if (accept_s) begin
      instruction <= NOP;
      if_id_valid <= 1'b0;
    end else begin
      instruction <= instruction;
      if_id_pc    <= if_id_pc;
      if_id_valid <= if_id_valid;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // One-cycle flag following a redirect to a non-word-aligned target.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      if_misalign <= 1'b0;
    end else begin
      if_misalign <= ex_redirect && (ex_redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        res_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic [31:0] instruction;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk           (clk),
    .res_n         (res_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .ex_redirect   (ex_redirect),
    .ex_redirect_pc(ex_redirect_pc),
    .instruction   (instruction),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .if_misalign   (if_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after changing inputs.
  task automatic settle();
    #1;
  endtask

  // One full fetch: grant at exp_addr, rvalid next cycle, IF/ID loaded after.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
    imem_gnt = 1'b1; imem_rvalid = 1'b0; settle();
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    tick();
    imem_rvalid = 1'b1; imem_rdata = data; settle();
    check("wait_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b0;
    check("load_instr", instruction, data);
    check("load_pc", if_id_pc, exp_addr);
    check("load_valid", {31'd0, if_id_valid}, 32'd1);
  endtask

  initial begin
    res_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_stall = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = 32'h0;

    // Reset state
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
    check("rst_misalign", {31'd0, if_misalign}, 32'd0);
`endif
    res_n = 1'b1;

    // Sequential fetches 0,4,8
    fetch_one(32'h0, 32'h1111_1111);
    imem_gnt = 1'b1; settle();
    check("seq_addr4", imem_addr, 32'h4);
    tick();
    check("bubble_valid", {31'd0, if_id_valid}, 32'd0);
    check("bubble_instr", instruction, 32'h0000_0013);
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; tick(); imem_rvalid = 1'b0;
    check("seq_pc4", if_id_pc, 32'h4);
    fetch_one(32'h8, 32'h3333_3333);

    // Stall for three cycles while the next word returns -> HOLD
    id_stall = 1'b1; imem_gnt = 1'b1; settle();
    check("stall_addr", imem_addr, 32'hC);
    tick();
    check("stall1_instr", instruction, 32'h3333_3333);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; tick(); imem_rvalid = 1'b0;
    check("stall2_instr", instruction, 32'h3333_3333);
    check("stall2_pc", if_id_pc, 32'h8);
    settle();
    check("hold_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("stall3_valid", {31'd0, if_id_valid}, 32'd1);
    check("stall3_instr", instruction, 32'h3333_3333);
    id_stall = 1'b0; tick();
    check("unstall_instr", instruction, 32'h0050_0093);
    check("unstall_pc", if_id_pc, 32'hC);
    check("unstall_valid", {31'd0, if_id_valid}, 32'd1);

    // Redirect while WAIT without rvalid -> KILL drops the late data
    imem_gnt = 1'b1; settle();
    check("pre_kill_addr", imem_addr, 32'h10);
    tick();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h100; tick(); ex_redirect = 1'b0;
    check("redir_valid", {31'd0, if_id_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; settle();
    check("kill_req", {31'd0, imem_req}, 32'd0);
    tick(); imem_rvalid = 1'b0;
    check("kill_instr", instruction, 32'h0000_0013);
    check("kill_valid", {31'd0, if_id_valid}, 32'd0);
    fetch_one(32'h100, 32'h4444_4444);

    // Redirect + stall with valid IF/ID, misaligned target 0x102
    ex_redirect = 1'b1; ex_redirect_pc = 32'h102; id_stall = 1'b1; settle();
    check("redir_fetch_req", {31'd0, imem_req}, 32'd0);
    tick();
    ex_redirect = 1'b0; id_stall = 1'b0;
    check("redir_stall_valid", {31'd0, if_id_valid}, 32'd0);
    check("redir_stall_instr", instruction, 32'h0000_0013);
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign_hi", {31'd0, if_misalign}, 32'd1);
`endif
    imem_gnt = 1'b0; settle();
    check("aligned_addr", imem_addr, 32'h100);
    tick();
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign_lo", {31'd0, if_misalign}, 32'd0);
`endif

    // Redirect in WAIT with same-cycle rvalid -> FETCH at target, data dropped
    imem_gnt = 1'b1; tick();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h300; imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    ex_redirect = 1'b0; imem_rvalid = 1'b0; settle();
    check("wrv_instr", instruction, 32'h0000_0013);
    check("wrv_req", {31'd0, imem_req}, 32'd1);
    check("wrv_addr", imem_addr, 32'h300);

    // PC wrap at 0xFFFF_FFFC
    ex_redirect = 1'b1; ex_redirect_pc = 32'hFFFF_FFFC; tick(); ex_redirect = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h5555_5555);
    imem_gnt = 1'b1; settle();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", {31'd0, imem_req}, 32'd1);

    // Reset mid-transaction; late rvalid in FETCH must be ignored
    tick();
    res_n = 1'b0; settle();
    check("rst_mid_req", {31'd0, imem_req}, 32'd0);
    tick();
    res_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    tick(); imem_rvalid = 1'b0;
    check("late_instr", instruction, 32'h0000_0013);
    check("late_valid", {31'd0, if_id_valid}, 32'd0);
    imem_gnt = 1'b1; settle();
    check("late_req", {31'd0, imem_req}, 32'd1);
    check("late_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
